pc_gen: RTL and testbench

- Parametrised program-counter generator for the IF stage. It drives the fetch address and the instruction-memory chip enable.
- It runs a boot sequencer after reset and arbitrates redirects with fixed priority: flush, then branch, then sequential.
- A branch that arrives while IF is stalled is latched and taken when the stall releases.
- It feeds inst_rom/icache; the ctrl unit supplies stall and flush/new_pc; the ID stage supplies the branch.

---
 rtl/pc_pkg.sv | 30 +++
 rtl/pc_gen_if.sv | 32 +++
 rtl/pc_redirect_latch.sv | 38 +++
 rtl/pc_gen.sv | 140 ++++++++++++++
 tb/tb_pc_gen.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared constants for the IF-stage program-counter generator.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    // Sequencer state encoding
    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int DEFAULT_FETCH_BYTES = 4;
    localparam int FETCH_SHIFT         = $clog2(DEFAULT_FETCH_BYTES);

    // Values shared with the legacy def.v header
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Branch      = 1'b1;
    localparam logic NoStop      = 1'b0;

    // Number of alignment bits for a given fetch size
    function automatic int fetch_shift(input int bytes);
        return (bytes <= 1) ? 0 : $clog2(bytes);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_gen_if.sv
// ============================================================================
// Module      : pc_gen_if
// Description : Control/branch inputs and fetch outputs of the PC generator.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_gen_if #(
    parameter int PC_W = 32
);
    logic [5:0]      stall;
    logic            flush;
    logic [PC_W-1:0] new_pc;
    logic            branch_flag_i;
    logic [PC_W-1:0] branch_target_address_i;
    logic [PC_W-1:0] pc;
    logic            ce;
    logic            redirect_pending_o;
    logic            misalign_o;

    modport master (
        output stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        input  pc, ce, redirect_pending_o, misalign_o
    );

    modport slave (
        input  stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        output pc, ce, redirect_pending_o, misalign_o
    );
endinterface

`default_nettype wire

// File: rtl/pc_redirect_latch.sv
// ============================================================================
// Module      : pc_redirect_latch
// Description : Holds one pending redirect target; capture overwrites, clear wins.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_redirect_latch #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         capture,
    input  wire logic         clear,
    input  wire logic [W-1:0] target_in,
    output logic              valid,
    output logic [W-1:0]      target
);
    logic         r_valid;
    logic [W-1:0] r_target;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_target <= '0;
        end else if (clear) begin
            r_valid  <= 1'b0;
        end else if (capture) begin
            r_valid  <= 1'b1;
            r_target <= target_in;
        end
    end

    assign valid  = r_valid;
    assign target = r_target;
endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module      : pc_gen
// Description : IF-stage PC generator with boot sequencer and redirect priority.
//               Optional misaligned-target flag enabled by PC_MISALIGN_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_gen
    import pc_pkg::*;
#(
    parameter int          PC_W        = 32,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FETCH_BYTES = 4,
    parameter int          BOOT_CYCLES = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    pc_gen_if.slave   bus
);
    localparam int              c_shift    = fetch_shift(FETCH_BYTES);
    localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] c_inc      = PC_W'(FETCH_BYTES);
    localparam logic [3:0]      c_boot_end = 4'(BOOT_CYCLES - 1);

    logic [0:0]      r_state;
    logic [3:0]      r_boot_cnt;
    logic [PC_W-1:0] r_pc;
    logic            r_ce;

    logic            w_stall_if;
    logic            w_pc_upd;
    logic [PC_W-1:0] w_pc_next;
    logic            w_pend_cap;
    logic            w_pend_clr;
    logic            w_pend_valid;
    logic [PC_W-1:0] w_pend_target;

    assign w_stall_if = (bus.stall[0] != NoStop);

    always_comb begin
        w_pc_upd   = 1'b0;
        w_pc_next  = r_pc;
        w_pend_cap = 1'b0;
        w_pend_clr = 1'b0;
        if (r_state == RUN) begin
            if (bus.flush) begin
                w_pc_upd   = 1'b1;
                w_pc_next  = bus.new_pc;
                w_pend_clr = 1'b1;
            end else if (w_stall_if) begin
                w_pend_cap = (bus.branch_flag_i == Branch);
            end else if (bus.branch_flag_i == Branch) begin
                w_pc_upd   = 1'b1;
                w_pc_next  = bus.branch_target_address_i;
                w_pend_clr = 1'b1;
            end else if (w_pend_valid) begin
                w_pc_upd   = 1'b1;
                w_pc_next  = w_pend_target;
                w_pend_clr = 1'b1;
            end else begin
                w_pc_upd   = 1'b1;
                w_pc_next  = r_pc + c_inc;
            end
        end
    end

    // Boot sequencer: pc stays at the reset vector until ce is raised
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= BOOT;
            r_boot_cnt <= 4'd0;
            r_ce       <= ChipDisable;
            r_pc       <= c_reset_pc;
        end else begin
            case (r_state)
                BOOT: begin
                    r_boot_cnt <= r_boot_cnt + 4'd1;
                    if (r_boot_cnt == c_boot_end) begin
                        r_state <= RUN;
                        r_ce    <= ChipEnable;
                    end
                end
                default: begin
                    if (w_pc_upd) begin
                        r_pc <= w_pc_next;
                    end
                end
            endcase
        end
    end

    pc_redirect_latch #(
        .W (PC_W)
    ) u_pending (
        .clk       (clk),
        .rst       (rst),
        .capture   (w_pend_cap),
        .clear     (w_pend_clr),
        .target_in (bus.branch_target_address_i),
        .valid     (w_pend_valid),
        .target    (w_pend_target)
    );

    assign bus.pc                 = r_pc;
    assign bus.ce                 = r_ce;
    assign bus.redirect_pending_o = w_pend_valid;

`ifdef PC_MISALIGN_EN
    logic r_misalign;
    logic w_redirect;
    logic w_tgt_mis;

    // Any pc load other than the sequential increment is a redirect
    assign w_redirect = w_pc_upd &
                        (bus.flush | (bus.branch_flag_i == Branch) | w_pend_valid);

    generate
        if (c_shift > 0) begin : g_mis_chk
            assign w_tgt_mis = |w_pc_next[c_shift-1:0];
        end else begin : g_mis_none
            assign w_tgt_mis = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else if (w_pc_upd) begin
            r_misalign <= w_redirect & w_tgt_mis;
        end
    end

    assign bus.misalign_o = r_misalign;
`else
    assign bus.misalign_o = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module      : tb_pc_gen
// Description : Scoreboard bench for pc_gen (boot, redirects, pending, wrap, reset).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;
    localparam logic [31:0] c_rst_pc = 32'hBFC0_0000;
`ifdef PC_MISALIGN_EN
    localparam logic c_mis = 1'b1;
`else
    localparam logic c_mis = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    pc_gen_if #(.PC_W(32)) bus ();

    pc_gen #(
        .PC_W        (32),
        .RESET_PC    (c_rst_pc),
        .FETCH_BYTES (4),
        .BOOT_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge
    task automatic cyc(input logic [5:0] st, input logic br, input logic [31:0] tgt,
                       input logic fl, input logic [31:0] npc,
                       input logic [31:0] epc, input logic ece, input logic epend,
                       input logic emis, input string nm);
        exp_t e;
        @(negedge clk);
        bus.stall                   = st;
        bus.branch_flag_i           = br;
        bus.branch_target_address_i = tgt;
        bus.flush                   = fl;
        bus.new_pc                  = npc;
        e.pc = epc; e.ce = ece; e.pend = epend; e.mis = emis; e.name = nm;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q.size() != 0) begin
            e = q.pop_front();
            check({e.name, ".pc"},   bus.pc,                        e.pc);
            check({e.name, ".ce"},   {31'd0, bus.ce},               {31'd0, e.ce});
            check({e.name, ".pend"}, {31'd0, bus.redirect_pending_o}, {31'd0, e.pend});
            check({e.name, ".mis"},  {31'd0, bus.misalign_o},       {31'd0, e.mis});
        end
    end

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk); #3;
            n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
    endtask

    initial begin
        bus.stall = 6'd0; bus.flush = 1'b0; bus.new_pc = '0;
        bus.branch_flag_i = 1'b0; bus.branch_target_address_i = '0;
        repeat (2) @(posedge clk);
        #3;
        check("rst.pc", bus.pc, c_rst_pc);
        check("rst.ce", {31'd0, bus.ce}, 32'd0);
        check("rst.pend", {31'd0, bus.redirect_pending_o}, 32'd0);
        rst = 1'b1;

        // Boot: inputs ignored, ce rises on the third edge
        cyc(6'd0, 1, 32'h400, 1, 32'h100, c_rst_pc, 0, 0, 0, "boot1");
        cyc(6'd1, 1, 32'h400, 0, 32'h0,   c_rst_pc, 0, 0, 0, "boot2");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   c_rst_pc, 1, 0, 0, "boot3");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'hBFC0_0004, 1, 0, 0, "seq1");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'hBFC0_0008, 1, 0, 0, "seq2");
        // Direct branch
        cyc(6'd0, 0, 32'h0,   1, 32'h100, 32'h100, 1, 0, 0, "flush100");
        cyc(6'd0, 1, 32'h400, 0, 32'h0,   32'h400, 1, 0, 0, "br400");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'h404, 1, 0, 0, "seq404");
        // Branch during stall is held until release
        cyc(6'd0, 0, 32'h0,   1, 32'h200, 32'h200, 1, 0, 0, "flush200");
        cyc(6'd1, 1, 32'h800, 0, 32'h0,   32'h200, 1, 1, 0, "stbr1");
        cyc(6'd1, 0, 32'h0,   0, 32'h0,   32'h200, 1, 1, 0, "stbr2");
        cyc(6'd1, 0, 32'h0,   0, 32'h0,   32'h200, 1, 1, 0, "stbr3");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'h800, 1, 0, 0, "pendtake");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'h804, 1, 0, 0, "seq804");
        // Flush while stalled discards the pending target
        cyc(6'd1, 1, 32'h800, 0, 32'h0,   32'h804, 1, 1, 0, "pend800");
        cyc(6'd1, 1, 32'h900, 0, 32'h0,   32'h804, 1, 1, 0, "pend900");
        cyc(6'd1, 0, 32'h0,   1, 32'h180, 32'h180, 1, 0, 0, "stflush");
        cyc(6'd1, 0, 32'h0,   0, 32'h0,   32'h180, 1, 0, 0, "sthold");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'h184, 1, 0, 0, "seq184");
        // Newer pending target overwrites older
        cyc(6'd1, 1, 32'h800, 0, 32'h0,   32'h184, 1, 1, 0, "ow1");
        cyc(6'd1, 1, 32'hA00, 0, 32'h0,   32'h184, 1, 1, 0, "ow2");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'hA00, 1, 0, 0, "owtake");
        // Live branch beats stale pending target
        cyc(6'd1, 1, 32'hB00, 0, 32'h0,   32'hA00, 1, 1, 0, "stale");
        cyc(6'd0, 1, 32'hC00, 0, 32'h0,   32'hC00, 1, 0, 0, "live");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'hC04, 1, 0, 0, "seqC04");
        cyc(6'b111110, 0, 32'h0, 0, 32'h0, 32'hC08, 1, 0, 0, "histall");
        // Wrap-around
        cyc(6'd0, 0, 32'h0,   1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 0, 0, "flushtop");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'hFFFF_FFFC, 1, 0, 0, "top");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'h0, 1, 0, 0, "wrap");
        // Misaligned branch target
        cyc(6'd0, 1, 32'h402, 0, 32'h0,   32'h402, 1, 0, c_mis, "mis402");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'h406, 1, 0, 0, "misclr");
        // Asynchronous reset mid-stall with a pending target
        cyc(6'd1, 1, 32'h700, 0, 32'h0,   32'h406, 1, 1, 0, "prerst");
        drain();
        bus.stall = 6'd1;
        bus.branch_flag_i = 1'b0;
        rst = 1'b0;
        #1;
        check("arst.pc", bus.pc, c_rst_pc);
        check("arst.ce", {31'd0, bus.ce}, 32'd0);
        check("arst.pend", {31'd0, bus.redirect_pending_o}, 32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   c_rst_pc, 0, 0, 0, "reboot1");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   c_rst_pc, 0, 0, 0, "reboot2");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   c_rst_pc, 1, 0, 0, "reboot3");
        cyc(6'd0, 0, 32'h0,   0, 32'h0,   32'hBFC0_0004, 1, 0, 0, "reseq");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
